// File: rtl/aap_pkg.sv
// Shared encodings, field positions and types for the AAP decode stage.
package aap_pkg;

  localparam logic [1:0] CLS_ALU    = 2'b00;
  localparam logic [1:0] CLS_MEM    = 2'b01;
  localparam logic [1:0] CLS_BRANCH = 2'b10;
  localparam logic [1:0] CLS_MISC   = 2'b11;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_BRA = 4'b0000;
  localparam logic [3:0] OP_BAL = 4'b0001;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JAL = 4'b0101;

  typedef enum logic [2:0] {
    JE_NONE     = 3'd0,
    JE_REL      = 3'd1,
    JE_ABS      = 3'd2,
    JE_ABS_LINK = 3'd3,
    JE_REL_LINK = 3'd4
  } jump_en_t;

  localparam logic [15:0] BUBBLE_WORD_DEFAULT = 16'h0001;

  localparam int LONG_BIT = 15;
  localparam int CLS_HI   = 14;
  localparam int CLS_LO   = 13;
  localparam int OP_HI    = 12;
  localparam int OP_LO    = 9;
  localparam int RD_HI    = 8;
  localparam int RD_LO    = 6;
  localparam int RA_HI    = 5;
  localparam int RA_LO    = 3;
  localparam int RB_HI    = 2;
  localparam int RB_LO    = 0;

  typedef enum logic [1:0] {RUN, SKIP, HOLD} state_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  cls;
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] imm;
    logic        is_long;
  } dec_fields_t;

  typedef struct packed {
    logic [2:0] je;
    logic [8:0] chg;
    logic [5:0] loc;
    logic       flush;
    logic       nop_stop;
    logic       link;
  } ctl_t;

endpackage

// File: rtl/aap_decode_if.sv
// Fetch window in, decoded fields and fetch control out.
interface aap_decode_if;
  logic [31:0] fetchoutput;
  logic [2:0]  pcjumpenable;
  logic [8:0]  pcchange;
  logic [5:0]  pclocation;
  logic        flush;
  logic        nop_stop;
  logic        dec_valid;
  logic [1:0]  dec_class;
  logic [3:0]  dec_opcode;
  logic [2:0]  dec_rd;
  logic [2:0]  dec_ra;
  logic [2:0]  dec_rb;
  logic [15:0] dec_imm;
  logic        dec_long;
  logic        dec_link;

  modport master (
    output fetchoutput,
    input  pcjumpenable, pcchange, pclocation, flush, nop_stop,
           dec_valid, dec_class, dec_opcode, dec_rd, dec_ra, dec_rb,
           dec_imm, dec_long, dec_link
  );

  modport slave (
    input  fetchoutput,
    output pcjumpenable, pcchange, pclocation, flush, nop_stop,
           dec_valid, dec_class, dec_opcode, dec_rd, dec_ra, dec_rb,
           dec_imm, dec_long, dec_link
  );
endinterface

// File: rtl/aap_decode_fields.sv
// Combinational field/immediate extraction from the {W0, W1} fetch window.
module aap_decode_fields import aap_pkg::*; #(
  parameter logic [15:0] BUBBLE_WORD = BUBBLE_WORD_DEFAULT
) (
  input  logic [31:0]  fetch_word,
  output dec_fields_t  fields
);
  logic [15:0] w0, w1;
  logic        unused_w1;

  assign w0 = fetch_word[31:16];
  assign w1 = fetch_word[15:0];
  assign unused_w1 = ^w1[14:13];

  always_comb begin
    fields         = '0;
    fields.cls     = w0[CLS_HI:CLS_LO];
    fields.opcode  = w0[OP_HI:OP_LO];
    fields.rd      = w0[RD_HI:RD_LO];
    fields.ra      = w0[RA_HI:RA_LO];
    fields.rb      = w0[RB_HI:RB_LO];
    fields.is_long = w0[LONG_BIT];
    if (w0[LONG_BIT])
      fields.imm = {w1[12:0], w0[2:0]};
    else if (w0[CLS_HI:CLS_LO] == CLS_BRANCH)
      fields.imm = {{7{w0[8]}}, w0[8:0]};
    else
      fields.imm = {{13{w0[2]}}, w0[2:0]};
    // A long word whose second half lacks the continuation bit is not an instruction.
    fields.valid = (w0 != BUBBLE_WORD) && (w0 != '0) && !(w0[LONG_BIT] && !w1[LONG_BIT]);
  end
endmodule

// File: rtl/aap_decode.sv
// AAP decode stage: registered field decode plus branch resolution and hold FSM.
module aap_decode import aap_pkg::*; #(
  parameter int unsigned BRANCH_HOLD = 2,
  parameter logic [15:0] HALT_IMM    = 16'd1,
  parameter logic [15:0] BUBBLE_WORD = BUBBLE_WORD_DEFAULT
) (
  input logic         clock,
  input logic         reset,
  aap_decode_if.slave bus
);
  dec_fields_t f, fld_d, fld_q;
  ctl_t        ctl_d, ctl_q;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        is_jump, is_halt;

  aap_decode_fields #(.BUBBLE_WORD(BUBBLE_WORD)) u_fields (
    .fetch_word (bus.fetchoutput),
    .fields     (f)
  );

  assign is_jump = f.valid && (f.cls == CLS_BRANCH) &&
                   (f.opcode inside {OP_BRA, OP_BAL, OP_JMP, OP_JAL});
  assign is_halt = f.valid && (f.cls == CLS_ALU) && (f.opcode == OP_NOP) && (f.imm == HALT_IMM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fld_d   = '0;
    ctl_d   = '0;
    case (state_q)
      RUN: begin
        if (f.valid) begin
          fld_d          = f;
          ctl_d.nop_stop = is_halt;
          if (is_jump) begin
            // A long branch's second half is swallowed by HOLD, so no SKIP here.
            ctl_d.flush = 1'b1;
            state_d     = HOLD;
            cnt_d       = 3'(BRANCH_HOLD - 1);
            case (f.opcode)
              OP_BRA: begin ctl_d.je = JE_REL;      ctl_d.chg = f.imm[8:0]; end
              OP_BAL: begin ctl_d.je = JE_REL_LINK; ctl_d.chg = f.imm[8:0]; ctl_d.link = 1'b1; end
              OP_JMP: begin ctl_d.je = JE_ABS;      ctl_d.loc = f.imm[5:0]; end
              OP_JAL: begin ctl_d.je = JE_ABS_LINK; ctl_d.loc = f.imm[5:0]; ctl_d.link = 1'b1; end
              default: ;
            endcase
          end else if (f.is_long) begin
            state_d = SKIP;
          end
        end
      end
      SKIP: state_d = RUN;
      HOLD: begin
        ctl_d.chg = ctl_q.chg;
        ctl_d.loc = ctl_q.loc;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          ctl_d.je    = ctl_q.je;
          ctl_d.flush = 1'b1;
          cnt_d       = cnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      fld_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fld_q   <= fld_d;
      ctl_q   <= ctl_d;
    end
  end

  assign bus.pcjumpenable = ctl_q.je;
  assign bus.pcchange     = ctl_q.chg;
  assign bus.pclocation   = ctl_q.loc;
  assign bus.flush        = ctl_q.flush;
  assign bus.nop_stop     = ctl_q.nop_stop;
  assign bus.dec_link     = ctl_q.link;
  assign bus.dec_valid    = fld_q.valid;
  assign bus.dec_class    = fld_q.cls;
  assign bus.dec_opcode   = fld_q.opcode;
  assign bus.dec_rd       = fld_q.rd;
  assign bus.dec_ra       = fld_q.ra;
  assign bus.dec_rb       = fld_q.rb;
  assign bus.dec_imm      = fld_q.imm;
  assign bus.dec_long     = fld_q.is_long;
endmodule

// File: tb/tb_aap_decode.sv
// Directed table-driven bench for aap_decode, plus a reset-during-HOLD sequence.
module tb_aap_decode;
  import aap_pkg::*;

  logic clock;
  logic reset;
  aap_decode_if bus();

  aap_decode #(.BRANCH_HOLD(2), .HALT_IMM(16'd1), .BUBBLE_WORD(16'h0001)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] fo;
    logic        v;
    logic [1:0]  cls;
    logic [3:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [15:0] imm;
    logic        lng, link;
    logic [2:0]  je;
    logic [8:0]  chg;
    logic [5:0]  loc;
    logic        fl, stop;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] fo, input logic v,
                              input logic [1:0] cls, input logic [3:0] op,
                              input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                              input logic [15:0] imm, input logic lng, input logic link,
                              input logic [2:0] je, input logic [8:0] chg, input logic [5:0] loc,
                              input logic fl, input logic stop);
    vec_t t;
    t.name = name; t.fo = fo; t.v = v; t.cls = cls; t.op = op;
    t.rd = rd; t.ra = ra; t.rb = rb; t.imm = imm; t.lng = lng; t.link = link;
    t.je = je; t.chg = chg; t.loc = loc; t.fl = fl; t.stop = stop;
    return t;
  endfunction

  // Present one window, let one edge sample it, compare on the falling edge.
  task automatic apply(input vec_t t);
    bus.fetchoutput = t.fo;
    @(posedge clock);
    @(negedge clock);
    chk({t.name, ".ctl"},
        64'({bus.dec_valid, bus.pcjumpenable, bus.flush, bus.nop_stop}),
        64'({t.v, t.je, t.fl, t.stop}));
    if (t.v)
      chk({t.name, ".fields"},
          64'({bus.dec_class, bus.dec_opcode, bus.dec_rd, bus.dec_ra, bus.dec_rb,
               bus.dec_imm, bus.dec_long, bus.dec_link}),
          64'({t.cls, t.op, t.rd, t.ra, t.rb, t.imm, t.lng, t.link}));
    if (t.je == JE_REL || t.je == JE_REL_LINK)
      chk({t.name, ".pcchange"}, 64'(bus.pcchange), 64'(t.chg));
    else if (t.je == JE_ABS || t.je == JE_ABS_LINK)
      chk({t.name, ".pclocation"}, 64'(bus.pclocation), 64'(t.loc));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.pcjumpenable, bus.pcchange, bus.pclocation, bus.flush, bus.nop_stop,
                bus.dec_valid, bus.dec_class, bus.dec_opcode, bus.dec_rd, bus.dec_ra,
                bus.dec_rb, bus.dec_imm, bus.dec_long, bus.dec_link});
  endfunction

  initial begin
    reset = 1'b0;
    bus.fetchoutput = 32'h0A53_0000;
    #2;
    chk("reset_outputs", all_outs(), 64'd0);

    //                 name         window        v  cls   op    rd    ra    rb    imm       lng link je    chg     loc    fl stop
    tbl.push_back(mk("alu",        32'h0A53_0000, 1, 2'd0, 4'd5, 3'd1, 3'd2, 3'd3, 16'h0003, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("bubble",     32'h0001_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("zero",       32'h0000_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("halt",       32'h0009_0000, 1, 2'd0, 4'd0, 3'd0, 3'd1, 3'd1, 16'h0001, 0, 0, 3'd0, 9'h000, 6'h00, 0, 1));
    tbl.push_back(mk("after_halt", 32'h0A53_0000, 1, 2'd0, 4'd5, 3'd1, 3'd2, 3'd3, 16'h0003, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("neg_imm",    32'h2E5C_0000, 1, 2'd1, 4'd7, 3'd1, 3'd3, 3'd4, 16'hFFFC, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("bra",        32'h41FD_0000, 1, 2'd2, 4'd0, 3'd7, 3'd7, 3'd5, 16'hFFFD, 0, 0, 3'd1, 9'h1FD, 6'h00, 1, 0));
    tbl.push_back(mk("bra_hold",   32'h0A53_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd1, 9'h1FD, 6'h00, 1, 0));
    tbl.push_back(mk("bra_end",    32'h0009_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("post_bra",   32'h0A53_0000, 1, 2'd0, 4'd5, 3'd1, 3'd2, 3'd3, 16'h0003, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("jal",        32'h4A2A_0000, 1, 2'd2, 4'd5, 3'd0, 3'd5, 3'd2, 16'h002A, 0, 1, 3'd3, 9'h000, 6'h2A, 1, 0));
    tbl.push_back(mk("jal_hold",   32'h0A53_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd3, 9'h000, 6'h2A, 1, 0));
    tbl.push_back(mk("jal_end",    32'h0A53_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("long",       32'h8005_8123, 1, 2'd0, 4'd0, 3'd0, 3'd0, 3'd5, 16'h091D, 1, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("long_skip",  32'h0A53_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("post_skip",  32'h0A53_0000, 1, 2'd0, 4'd5, 3'd1, 3'd2, 3'd3, 16'h0003, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("long_bad",   32'h8005_0123, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("no_skip",    32'h0A53_0000, 1, 2'd0, 4'd5, 3'd1, 3'd2, 3'd3, 16'h0003, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("long_halt",  32'h8001_8000, 1, 2'd0, 4'd0, 3'd0, 3'd0, 3'd1, 16'h0001, 1, 0, 3'd0, 9'h000, 6'h00, 0, 1));
    tbl.push_back(mk("halt_skip",  32'h0009_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("long_bal",   32'hC203_8004, 1, 2'd2, 4'd1, 3'd0, 3'd0, 3'd3, 16'h0023, 1, 1, 3'd4, 9'h023, 6'h00, 1, 0));
    tbl.push_back(mk("bal_hold",   32'h0A53_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd4, 9'h023, 6'h00, 1, 0));
    tbl.push_back(mk("bal_end",    32'h0A53_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("jmp",        32'h483F_0000, 1, 2'd2, 4'd4, 3'd0, 3'd7, 3'd7, 16'h003F, 0, 0, 3'd2, 9'h000, 6'h3F, 1, 0));
    tbl.push_back(mk("jmp_hold",   32'h0000_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd2, 9'h000, 6'h3F, 1, 0));
    tbl.push_back(mk("jmp_end",    32'h0000_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("br_other",   32'h4405_0000, 1, 2'd2, 4'd2, 3'd0, 3'd0, 3'd5, 16'h0005, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    tbl.push_back(mk("post_other", 32'h0A53_0000, 1, 2'd0, 4'd5, 3'd1, 3'd2, 3'd3, 16'h0003, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));

    @(negedge clock);
    reset = 1'b1;
    foreach (tbl[i]) apply(tbl[i]);

    // Reset asserted while HOLD is active, then released into a plain ALU word.
    apply(mk("rst_bra", 32'h41FD_0000, 1, 2'd2, 4'd0, 3'd7, 3'd7, 3'd5, 16'hFFFD, 0, 0, 3'd1, 9'h1FD, 6'h00, 1, 0));
    bus.fetchoutput = 32'h0A53_0000;
    @(posedge clock);
    #2;
    chk("hold_active", 64'(bus.pcjumpenable), 64'(JE_REL));
    reset = 1'b0;
    #1;
    chk("reset_mid_hold", all_outs(), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    apply(mk("post_reset", 32'h0A53_0000, 1, 2'd0, 4'd5, 3'd1, 3'd2, 3'd3, 16'h0003, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));
    apply(mk("post_reset2", 32'h0000_0000, 0, 2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 0, 3'd0, 9'h000, 6'h00, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aap_decode.md
Name: aap_decode

Overview:
- Decode stage of the AAP pipeline, directly downstream of the fetch stage.
- Consumes the 32-bit fetch window: current word in bits [31:16], next word in bits [15:0].
- Decodes 16- and 32-bit instructions into registered fields for execute.
- Resolves branches and jumps, returning pcjumpenable, pcchange, pclocation and flush to fetch, and raises nop_stop on the halt NOP.

Parameters:
- BRANCH_HOLD, 2: cycles a jump request is held towards fetch; legal range 1..7.
- HALT_IMM, 1: immediate of the NOP that asserts nop_stop.
- BUBBLE_WORD, 16'h0001: word fetch injects as a bubble; decoded as no-op.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- fetchoutput, input, 32: [31:16] current word W0, [15:0] next word W1.
- pcjumpenable, output, 3: 0 none, 1 relative, 2 absolute, 3 absolute+link, 4 relative+link.
- pcchange, output, 9: relative offset in words.
- pclocation, output, 6: absolute target word address.
- flush, output, 1: squash the word fetch is currently presenting.
- nop_stop, output, 1: one-cycle halt request.
- dec_valid, output, 1: decoded fields are a real instruction.
- dec_class, output, 2: W0[14:13].
- dec_opcode, output, 4: W0[12:9].
- dec_rd, output, 3: W0[8:6].
- dec_ra, output, 3: W0[5:3].
- dec_rb, output, 3: W0[2:0].
- dec_imm, output, 16: sign-extended immediate.
- dec_long, output, 1: 32-bit instruction.
- dec_link, output, 1: write the return address to the link register.

Behaviour:
- Reset (reset=0), asynchronous:
  - State RUN, all outputs 0, hold counter 0.
  - Reset released mid-branch resumes in RUN with no request pending.
- Latency: one cycle. Every dec_* output and every fetch-control output is registered from the fetchoutput sampled at the previous edge.
- Word classification:
  - W0 == BUBBLE_WORD or W0 == 0: dec_valid=0, no control.
  - W0[15]=1: long form. Requires W1[15]=1; if W1[15]=0, treat as bubble (dec_valid=0).
- Immediates:
  - Short: class 10 (branch) imm = sext(W0[8:0]); otherwise imm = sext(W0[2:0]).
  - Long: imm = {W1[12:0], W0[2:0]}, 16 bits, no extension.
- Branch class (10) opcodes:
  - 0000 BRA: pcjumpenable=1, pcchange=imm[8:0].
  - 0001 BAL: pcjumpenable=4, pcchange=imm[8:0], dec_link=1.
  - 0100 JMP: pcjumpenable=2, pclocation=imm[5:0].
  - 0101 JAL: pcjumpenable=3, pclocation=imm[5:0], dec_link=1.
  - Any other opcode: dec_valid=1, no control.
- Halt NOP: class 00, opcode 0000, imm == HALT_IMM gives nop_stop=1 for exactly one cycle, dec_valid=1.
- FSM states:
  - RUN: decode W0.
    - Short non-branch: stay in RUN.
    - Long non-branch: go to SKIP.
    - Branch (either length): go to HOLD; load counter = BRANCH_HOLD-1.
  - SKIP: W0 is the second half of the prior long word. Output a bubble (dec_valid=0), return to RUN.
  - HOLD:
    - pcjumpenable, pcchange and pclocation stay at their latched values; flush=1; dec_valid=0.
    - Counter decrements each cycle; at 0 the next state is RUN and pcjumpenable returns to 0.
    - Words arriving during HOLD are discarded, including a halt NOP.
- Long branch: goes to HOLD, not SKIP; the second half is absorbed by HOLD.
- In RUN, flush=1 only in the cycle a branch is first issued.
- pcchange is the raw 9-bit two's-complement field; fetch performs the PC arithmetic with 6-bit wrap.
- Simultaneous long + halt NOP (class 00, opcode 0000, long imm == HALT_IMM): nop_stop fires and SKIP still follows.

Decomposition:
- Shared package aap_pkg holds:
  - class codes, branch opcodes and pcjumpenable encodings (JE_NONE..JE_REL_LINK);
  - BUBBLE_WORD and the field bit positions;
  - the FSM state typedef (RUN, SKIP, HOLD).
- One sub-module is natural: aap_decode_fields, purely combinational field and immediate extraction from {W0, W1}.
- The FSM, hold counter and output registers stay in aap_decode.

Test Plan:
- Reset mid-HOLD: reset=0 asserted while HOLD is active -> all outputs 0 immediately; after release the first short ALU word decodes normally.
- Short ALU 16'h0A53 -> next cycle dec_valid=1, class 00, opcode 0101, rd=1, ra=2, rb=3, imm=16'h0003, dec_long=0.
- BRA with offset -3, W0=16'h41FD -> pcjumpenable=1 and pcchange=9'h1FD for 2 cycles, flush=1 both cycles; the two following words give dec_valid=0; then pcjumpenable=0.
- JAL with target 6'h2A, W0=16'h4A2A -> pcjumpenable=3, pclocation=6'h2A, dec_link=1.
- Long word W0=16'h8005, W1=16'h8123 -> dec_long=1, imm=16'h091D; the next cycle is a bubble (SKIP).
- Halt: W0=16'h0001 injected by fetch gives no nop_stop; NOP with imm=1 at W0=16'h0009 -> nop_stop=1 for one cycle only.
